ras_ckpt_q: RTL

RAS_CKPT_Q -- requirements
Module: ras_ckpt_q

---
 rtl/ras_ckpt_q.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ras_ckpt_q.sv
// -----------------------------------------------------------------------------
// ras_ckpt_q
//
// Checkpoint queue for the return-address-stack pointer. Every predicted
// control-flow instruction leaving the RESP stage takes one slot and stores
// the RAS stack pointer to restore if that instruction turns out to be
// mispredicted. Slots are allocated in program order (circular FIFO). They
// are freed from the head on correct resolution. On a mispredict, the queue
// is truncated just after the offending slot, and a one-cycle restore request
// is sent to the RAS update port.
//
// Ports
//   CLK               in   clock, rising-edge
//   nRST              in   asynchronous active-low reset
//   enq_valid         in   request a checkpoint for a predicted CF instruction
//   enq_ras_index     in   RAS sp to restore on mispredict (already adjusted)
//   enq_ready         out  a slot is available this cycle
//   enq_ckpt_id       out  slot id given to an accepted enqueue
//   commit_valid      in   oldest checkpoint resolved correctly, free it
//   mispred_valid     in   a checkpointed instruction mispredicted
//   mispred_ckpt_id   in   slot id of the mispredicted instruction
//   update0_valid     out  registered RAS sp restore request (one cycle)
//   update0_ras_index out  registered sp value to restore
//   ckpt_count        out  number of live checkpoints
// -----------------------------------------------------------------------------
module ras_ckpt_q #(
   parameter  int CKPT_ENTRIES    = 8,
   parameter  int RAS_INDEX_WIDTH = 3,
   localparam int CKPT_ID_WIDTH   = $clog2(CKPT_ENTRIES)
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       enq_valid,
   input  logic [RAS_INDEX_WIDTH-1:0] enq_ras_index,
   output logic                       enq_ready,
   output logic [CKPT_ID_WIDTH-1:0]   enq_ckpt_id,
   input  logic                       commit_valid,
   input  logic                       mispred_valid,
   input  logic [CKPT_ID_WIDTH-1:0]   mispred_ckpt_id,
   output logic                       update0_valid,
   output logic [RAS_INDEX_WIDTH-1:0] update0_ras_index,
   output logic [CKPT_ID_WIDTH:0]     ckpt_count
);

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   typedef logic [CKPT_ID_WIDTH:0] ptr_t;

   localparam ptr_t PTR_ONE = ptr_t'(1);

   ptr_t                       head_reg;
   ptr_t                       head_next;
   ptr_t                       tail_reg;
   ptr_t                       tail_next;

   logic [RAS_INDEX_WIDTH-1:0] slot_reg [CKPT_ENTRIES];
   logic [CKPT_ENTRIES-1:0]    slot_wr;

   logic                       update0_valid_reg;
   logic [RAS_INDEX_WIDTH-1:0] update0_ras_index_reg;
   logic [RAS_INDEX_WIDTH-1:0] update0_ras_index_next;

   logic                       empty;
   logic                       full;
   ptr_t                       count;
   logic                       enq_fire;
   logic                       commit_fire;

   logic [CKPT_ID_WIDTH-1:0]   mispred_offset;
   logic                       mispred_hit;
   ptr_t                       mispred_ptr;

   // ---------------------------------------------------------------------
   // Occupancy
   // ---------------------------------------------------------------------
   assign count = tail_reg - head_reg;
   assign empty = (head_reg == tail_reg);
   assign full  = (head_reg[CKPT_ID_WIDTH-1:0] == tail_reg[CKPT_ID_WIDTH-1:0]) &&
                  (head_reg[CKPT_ID_WIDTH] != tail_reg[CKPT_ID_WIDTH]);

   // A mispredict in flight blocks allocation outright, even if its id turns
   // out to be stale: the front end is being redirected anyway, and this keeps
   // enq_ready independent of the live-range comparison.
   assign enq_ready   = ~full & ~mispred_valid;
   assign enq_ckpt_id = tail_reg[CKPT_ID_WIDTH-1:0];
   assign ckpt_count  = count;

   assign enq_fire    = enq_valid & enq_ready;
   assign commit_fire = commit_valid & ~empty;

   // ---------------------------------------------------------------------
   // Mispredict validation
   //
   // The distance from the head slot to the mispredicted slot, taken modulo
   // the slot count, is that checkpoint's age rank. The id is live only when
   // this rank is below the occupancy. The rank is added back onto the full
   // head pointer, which gives the wrap-correct pointer of that slot.
   // ---------------------------------------------------------------------
   assign mispred_offset = mispred_ckpt_id - head_reg[CKPT_ID_WIDTH-1:0];
   assign mispred_hit    = mispred_valid && ({1'b0, mispred_offset} < count);
   assign mispred_ptr    = head_reg + {1'b0, mispred_offset};

   // ---------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------
   always_comb begin
      head_next              = head_reg;
      tail_next              = tail_reg;
      update0_ras_index_next = update0_ras_index_reg;

      // A live mispredict implies a non-empty queue, so a same-cycle commit
      // still frees the head. When both hit the head slot, head and tail meet
      // and the queue drains to empty.
      if (commit_fire) begin
         head_next = head_reg + PTR_ONE;
      end

      // Enqueue and mispredict are mutually exclusive because enq_ready
      // drops whenever mispred_valid is high.
      if (mispred_hit) begin
         tail_next              = mispred_ptr + PTR_ONE;
         update0_ras_index_next = slot_reg[mispred_ckpt_id];
      end else if (enq_fire) begin
         tail_next = tail_reg + PTR_ONE;
      end
   end

   // ---------------------------------------------------------------------
   // Per-slot write enables
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < CKPT_ENTRIES; gi++) begin : g_slot_wr
         assign slot_wr[gi] = enq_fire &&
                              (tail_reg[CKPT_ID_WIDTH-1:0] == CKPT_ID_WIDTH'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head_reg              <= '0;
         tail_reg              <= '0;
         update0_valid_reg     <= 1'b0;
         update0_ras_index_reg <= '0;
      end else begin
         head_reg              <= head_next;
         tail_reg              <= tail_next;
         update0_valid_reg     <= mispred_hit;
         update0_ras_index_reg <= update0_ras_index_next;
      end
   end

   // Slot storage is cleared on reset, so it lives in flops instead of RAM.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < CKPT_ENTRIES; i++) begin
            slot_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CKPT_ENTRIES; i++) begin
            if (slot_wr[i]) begin
               slot_reg[i] <= enq_ras_index;
            end
         end
      end
   end

   assign update0_valid     = update0_valid_reg;
   assign update0_ras_index = update0_ras_index_reg;

endmodule
